// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch ingress stage: the {addr,data}
// transaction record, the source id and a saturating statistics increment.
package switch_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int STAT_WIDTH     = 16;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } txn_t;

  typedef logic src_id_t;

  localparam src_id_t SRC0 = 1'b0;
  localparam src_id_t SRC1 = 1'b1;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    if (v == {STAT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + STAT_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/switch_ingress_fifo.sv
// Per-source circular FIFO; ready comes straight from the registered count,
// so a pop only frees a slot for the pusher in the following cycle.
module switch_ingress_fifo
  import switch_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type T          = txn_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  T     wdata,
  output logic ready,
  input  logic pop,
  output logic empty,
  output T     head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  T              mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign ready     = (count_r != FULL_CNT);
  assign empty     = (count_r == {CW{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && ready;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy tracking; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (rstn && do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/switch_ingress_arb.sv
// Two-source ingress buffer with round-robin merge into the registered
// vld/addr/data switch stream. SWITCH_INGRESS_STATS_EN adds per-source grant counters.
module switch_ingress_arb
  import switch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  stall,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
`ifdef SWITCH_INGRESS_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] grant_cnt0,
  output logic [STAT_WIDTH-1:0] grant_cnt1
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } item_t;

  item_t                 s0_item_s;
  item_t                 s1_item_s;
  item_t                 head0_s;
  item_t                 head1_s;
  item_t                 sel_s;
  logic                  empty0_s;
  logic                  empty1_s;
  logic                  grant_s;
  src_id_t               gsrc_s;
  logic                  pop0_s;
  logic                  pop1_s;
  src_id_t               rr_last_r;
  logic                  vld_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;

  assign s0_item_s = {s0_addr, s0_data};
  assign s1_item_s = {s1_addr, s1_data};
  assign pop0_s    = grant_s && (gsrc_s == SRC0);
  assign pop1_s    = grant_s && (gsrc_s == SRC1);

  switch_ingress_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(item_t)) u_fifo0 (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s0_valid),
    .wdata (s0_item_s),
    .ready (s0_ready),
    .pop   (pop0_s),
    .empty (empty0_s),
    .head  (head0_s)
  );

  switch_ingress_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(item_t)) u_fifo1 (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s1_valid),
    .wdata (s1_item_s),
    .ready (s1_ready),
    .pop   (pop1_s),
    .empty (empty1_s),
    .head  (head1_s)
  );

  // Round-robin grant: contention goes to whichever source was not served last.
  always_comb begin
    grant_s = 1'b0;
    gsrc_s  = SRC0;
    if (stall) begin
      grant_s = 1'b0;
      gsrc_s  = SRC0;
    end else if (!empty0_s && !empty1_s) begin
      grant_s = 1'b1;
      gsrc_s  = ~rr_last_r;
    end else if (!empty0_s) begin
      grant_s = 1'b1;
      gsrc_s  = SRC0;
    end else if (!empty1_s) begin
      grant_s = 1'b1;
      gsrc_s  = SRC1;
    end else begin
      grant_s = 1'b0;
      gsrc_s  = SRC0;
    end
  end

  // Head selection for the granted source.
  always_comb begin
    sel_s = head0_s;
    case (gsrc_s)
      SRC0:    sel_s = head0_s;
      SRC1:    sel_s = head1_s;
      default: sel_s = head0_s;
    endcase
  end

  // Issue register toward the switch; idle cycles drive all-zero payload.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_r     <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      rr_last_r <= SRC1;
    end else if (grant_s) begin
      vld_r     <= 1'b1;
      addr_r    <= sel_s.addr;
      data_r    <= sel_s.data;
      rr_last_r <= gsrc_s;
    end else begin
      vld_r     <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      rr_last_r <= rr_last_r;
    end
  end

  assign vld  = vld_r;
  assign addr = addr_r;
  assign data = data_r;

`ifdef SWITCH_INGRESS_STATS_EN
  logic [STAT_WIDTH-1:0] grant_cnt0_r;
  logic [STAT_WIDTH-1:0] grant_cnt1_r;

  // Saturating grant counters per source.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_cnt0_r <= {STAT_WIDTH{1'b0}};
      grant_cnt1_r <= {STAT_WIDTH{1'b0}};
    end else begin
      grant_cnt0_r <= pop0_s ? sat_inc(grant_cnt0_r) : grant_cnt0_r;
      grant_cnt1_r <= pop1_s ? sat_inc(grant_cnt1_r) : grant_cnt1_r;
    end
  end

  assign grant_cnt0 = grant_cnt0_r;
  assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_switch_ingress_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [7:0]  s0_addr, s1_addr, addr;
  logic [15:0] s0_data, s1_data, data;
  logic        stall, vld;
`ifdef SWITCH_INGRESS_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  switch_ingress_arb dut (
    .clk(clk), .rstn(rstn),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .stall(stall), .vld(vld), .addr(addr), .data(data)
`ifdef SWITCH_INGRESS_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } item_t;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [7:0]  a1;
    logic [15:0] d1;
    logic        st;
    logic        ev;
    logic [7:0]  ea;
    logic [15:0] ed;
  } vec_t;

  // Reference model: one queue per source, whose turn it is under contention,
  // and the transaction expected on the issue register after each edge.
  item_t       q0[$];
  item_t       q1[$];
  logic [8:0]  issued[$];
  logic        turn;
  logic        exp_vld;
  logic [7:0]  exp_addr;
  logic [15:0] exp_data;

  int   n_chk = 0;
  int   n_fail = 0;
  logic acc0, acc1;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; stall = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    q0.delete(); q1.delete();
    turn = 1'b0; exp_vld = 1'b0; exp_addr = 8'h00; exp_data = 16'h0000;
    chk("rst_vld", 32'(vld), 32'(1'b0));
    chk("rst_addr", 32'(addr), 32'(8'h00));
    chk("rst_data", 32'(data), 32'(16'h0000));
    chk("rst_ready0", 32'(s0_ready), 32'(1'b1));
    chk("rst_ready1", 32'(s1_ready), 32'(1'b1));
  endtask

  // One clock of stimulus; model predicts acceptance, grant and issued output.
  task automatic cycle(input logic v0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [7:0] a1, input logic [15:0] d1,
                       input logic st, output logic ok0, output logic ok1);
    item_t it;
    int    g;
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    stall = st;
    chk("ready0", 32'(s0_ready), 32'(q0.size() < DEPTH));
    chk("ready1", 32'(s1_ready), 32'(q1.size() < DEPTH));
    ok0 = v0 && (q0.size() < DEPTH);
    ok1 = v1 && (q1.size() < DEPTH);
    g = -1;
    if (!st) begin
      if (q0.size() > 0 && q1.size() > 0) g = turn ? 1 : 0;
      else if (q0.size() > 0) g = 0;
      else if (q1.size() > 0) g = 1;
    end
    it = '0;
    if (g == 0) begin
      it = q0.pop_front(); turn = 1'b1;
    end else if (g == 1) begin
      it = q1.pop_front(); turn = 1'b0;
    end
    exp_vld = (g >= 0); exp_addr = it.a; exp_data = it.d;
    if (g >= 0) issued.push_back({(g == 1), it.a});
    if (ok0) q0.push_back({a0, d0});
    if (ok1) q1.push_back({a1, d1});
    @(posedge clk); @(negedge clk);
    chk("vld", 32'(vld), 32'(exp_vld));
    chk("addr", 32'(addr), 32'(exp_addr));
    chk("data", 32'(data), 32'(exp_data));
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, acc0, acc1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4 && (q0.size() + q1.size()) > 0; i++) idle();
    chk("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    idle();
  endtask

  function automatic vec_t mk(logic rst, logic v0, logic [7:0] a0, logic [15:0] d0,
                              logic v1, logic [7:0] a1, logic [15:0] d1, logic st,
                              logic ev, logic [7:0] ea, logic [15:0] ed);
    vec_t r;
    r.rst = rst; r.v0 = v0; r.a0 = a0; r.d0 = d0; r.v1 = v1; r.a1 = a1; r.d1 = d1;
    r.st = st; r.ev = ev; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rstn = 1'b0; stall = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_addr = 8'h00; s0_data = 16'h0000; s1_addr = 8'h00; s1_data = 16'h0000;

    // Single-push latency, then dual-source interleave from a fresh reset.
    tbl[0]  = mk(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    tbl[1]  = mk(1'b0, 1'b1, 8'h10, 16'hABCD, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h10, 16'hABCD);
    tbl[3]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    tbl[4]  = mk(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    tbl[5]  = mk(1'b0, 1'b1, 8'h00, 16'h0A00, 1'b1, 8'h80, 16'h0B80, 1'b0, 1'b0, 8'h00, 16'h0000);
    tbl[6]  = mk(1'b0, 1'b1, 8'h01, 16'h0A01, 1'b1, 8'h81, 16'h0B81, 1'b0, 1'b1, 8'h00, 16'h0A00);
    tbl[7]  = mk(1'b0, 1'b1, 8'h02, 16'h0A02, 1'b1, 8'h82, 16'h0B82, 1'b0, 1'b1, 8'h80, 16'h0B80);
    tbl[8]  = mk(1'b0, 1'b1, 8'h03, 16'h0A03, 1'b1, 8'h83, 16'h0B83, 1'b0, 1'b1, 8'h01, 16'h0A01);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h81, 16'h0B81);
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h02, 16'h0A02);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h82, 16'h0B82);
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h03, 16'h0A03);
    tbl[13] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h83, 16'h0B83);
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        cycle(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].st, acc0, acc1);
        chk($sformatf("tbl%0d_vld", i), 32'(vld), 32'(tbl[i].ev));
        chk($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].ea));
        chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].ed));
      end
    end

    // Stalled fill of s1, a held fifth push, then release.
    do_reset(); issued.delete();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, 8'(8'h40 + i), 16'(16'h4000 + i), 1'b1, acc0, acc1);
    chk("t3_full_ready", 32'(s1_ready), 32'(1'b0));
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, 8'h44, 16'h4004, 1'b1, acc0, acc1);
    cycle(1'b0, 8'h00, 16'h0000, 1'b1, 8'h44, 16'h4004, 1'b0, acc0, acc1);
    chk("t3_ready_after_pop", 32'(s1_ready), 32'(1'b1));
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, 8'h44, 16'h4004, 1'b0, acc0, acc1);
      if (acc1) got = 1;
    end
    chk("t3_fifth_accepted", 32'(got), 32'd1);
    drain();
    chk("t3_issue_count", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      chk($sformatf("t3_order%0d", i), 32'(issued[i]), 32'({1'b1, 8'(8'h40 + i)}));

    // Twelve pushes through the depth-4 s0 FIFO with mostly-stalled draining.
    do_reset(); issued.delete();
    got = 0;
    for (int c = 0; c < 200 && got < 12; c++) begin
      cycle(1'b1, 8'(8'h20 + got), 16'(16'h2000 + got), 1'b0, 8'h00, 16'h0000,
            1'((c % 4) != 3), acc0, acc1);
      if (acc0) got++;
    end
    drain();
    chk("t4_issue_count", 32'(issued.size()), 32'd12);
    for (int i = 0; i < 12 && i < issued.size(); i++)
      chk($sformatf("t4_order%0d", i), 32'(issued[i]), 32'({1'b0, 8'(8'h20 + i)}));

    // Reset with both FIFOs partly full discards everything; s0 wins first.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'(8'h60 + i), 16'(16'h6000 + i), 1'b1, 8'(8'hE0 + i), 16'(16'hE000 + i),
            1'b1, acc0, acc1);
    do_reset(); issued.delete();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("t5_no_stale%0d", i), 32'(vld), 32'(1'b0));
    end
    cycle(1'b1, 8'h70, 16'h7000, 1'b1, 8'hF0, 16'hF000, 1'b0, acc0, acc1);
    idle();
    chk("t5_first_s0", 32'(addr), 32'(8'h70));
    drain();

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
              1'($urandom_range(0, 3) == 0), acc0, acc1);
      end
    end
    drain();

`ifdef SWITCH_INGRESS_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'(i), 16'(i), 1'b0, 8'h00, 16'h0000, 1'b0, acc0, acc1);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 8'h00, 16'h0000, 1'b1, 8'(i), 16'(i), 1'b0, acc0, acc1);
    drain();
    chk("t6_cnt0", 32'(grant_cnt0), 32'd3);
    chk("t6_cnt1", 32'(grant_cnt1), 32'd5);
    force dut.grant_cnt0_r = 16'hFFFF;
    cycle(1'b1, 8'h55, 16'h5555, 1'b0, 8'h00, 16'h0000, 1'b0, acc0, acc1);
    release dut.grant_cnt0_r;
    drain();
    chk("t6_saturate", 32'(grant_cnt0), 32'(16'hFFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
